// File: rtl/led_blink_pwm.sv
// led_blink_pwm: multi-channel LED driver with OFF / PWM-ON / BLINK (and optional BREATHE) modes per channel.
//   Ports: clk (rising edge), rst_n (async, active low), en (global enable; 0 clears all counters, LEDs off),
//          mode[2*NUM_CH] (ch i at [2i+1:2i]: 00 OFF, 01 ON, 10 BLINK, 11 BREATHE),
//          duty[PWM_BITS*NUM_CH] (ch i at [PWM_BITS*i +: PWM_BITS]), phase_inv[NUM_CH],
//          led_out[NUM_CH] (registered, 1 = lit), blink_tick (registered one-cycle pulse per blink toggle).
//   Optional feature: define LED_BREATHE_EN to add the shared breathe ramp; without it mode 11 drives 0.
module led_blink_pwm #(
    parameter int NUM_CH           = 2,
    parameter int TOGGLE_CYC       = 25_000_000,
    parameter int PWM_BITS         = 8,
    parameter int BREATHE_STEP_CYC = 49_019
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [2*NUM_CH-1:0]          mode,
    input  logic [PWM_BITS*NUM_CH-1:0]   duty,
    input  logic [NUM_CH-1:0]            phase_inv,
    output logic [NUM_CH-1:0]            led_out,
    output logic                         blink_tick
);
    localparam int BW = $clog2(TOGGLE_CYC);
    localparam logic [BW-1:0] B_LAST = BW'(TOGGLE_CYC - 1);
    // PWM period is 2**PWM_BITS-1 so that duty = all-ones means always lit
    localparam logic [PWM_BITS-1:0] P_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
    logic [BW-1:0]       blink_cnt;
    logic                blink_phase;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                blink_wrap;
    logic                breathe_on;
    logic [NUM_CH-1:0]   led_nxt;
    assign blink_wrap = blink_cnt == B_LAST;
`ifdef LED_BREATHE_EN
    localparam int SW = BREATHE_STEP_CYC > 1 ? $clog2(BREATHE_STEP_CYC) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(BREATHE_STEP_CYC - 1);
    logic [SW-1:0]       step_cnt;
    logic [PWM_BITS-1:0] level;
    logic                dir_down;
    logic                turn;
    // reverse at the extremes without dwelling: the turning step already moves away
    assign turn       = dir_down ? level == '0 : level == '1;
    assign breathe_on = pwm_cnt < level;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || !en) begin
            step_cnt <= '0;
            level    <= '0;
            dir_down <= 1'b0;
        end else if (step_cnt == S_LAST) begin
            step_cnt <= '0;
            dir_down <= dir_down ^ turn;
            level    <= (dir_down ^ turn) ? level - PWM_BITS'(1) : level + PWM_BITS'(1);
        end else begin
            step_cnt <= step_cnt + SW'(1);
        end
    end
`else
    assign breathe_on = 1'b0;
`endif
    always_comb begin
        led_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            led_nxt[i] = mode[2*i +: 2] == 2'b01 ? pwm_cnt < duty[PWM_BITS*i +: PWM_BITS] :
                         mode[2*i +: 2] == 2'b10 ? (blink_phase ^ phase_inv[i]) && pwm_cnt < duty[PWM_BITS*i +: PWM_BITS] :
                         mode[2*i +: 2] == 2'b11 && breathe_on;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= '0;
            led_out     <= '0;
            blink_tick  <= 1'b0;
        end else if (!en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            pwm_cnt     <= '0;
            led_out     <= '0;
            blink_tick  <= 1'b0;
        end else begin
            blink_cnt   <= blink_wrap ? '0 : blink_cnt + BW'(1);
            blink_phase <= blink_phase ^ blink_wrap;
            pwm_cnt     <= pwm_cnt == P_LAST ? '0 : pwm_cnt + PWM_BITS'(1);
            led_out     <= led_nxt;
            blink_tick  <= blink_wrap;
        end
    end
endmodule

// File: tb/tb_led_blink_pwm.sv
// tb_led_blink_pwm: directed and randomized checks of led_blink_pwm against an arithmetic model of enabled-cycle count.
module tb_led_blink_pwm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] mode = '0;
    logic [7:0] duty = '0;
    logic [1:0] phase_inv = '0;
    logic [1:0] led_out;
    logic       blink_tick;
    int         checks = 0;
    int         failures = 0;
    int         k = 0;
    led_blink_pwm #(.NUM_CH(2), .TOGGLE_CYC(10), .PWM_BITS(4), .BREATHE_STEP_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .duty(duty),
        .phase_inv(phase_inv), .led_out(led_out), .blink_tick(blink_tick)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h k=%0d t=%0t", tag, obs, exp, k, $time);
        end
    endtask
    // k = enabled edges since last reset/en-low; every counter is a pure function of it
    function automatic logic [1:0] model_led(input int kk, input logic [3:0] m, input logic [7:0] d, input logic [1:0] pi);
        logic [1:0] r;
        int pc, ph, s, lvl;
        pc  = kk % 15;
        ph  = (kk / 10) % 2;
        s   = (kk / 2) % 30;
        lvl = s <= 15 ? s : 30 - s;
        for (int c = 0; c < 2; c++) begin
            logic on;
            on = pc < int'(d[4*c +: 4]);
            case (m[2*c +: 2])
                2'b01:   r[c] = on;
                2'b10:   r[c] = (ph[0] ^ pi[c]) & on;
`ifdef LED_BREATHE_EN
                2'b11:   r[c] = pc < lvl;
`endif
                default: r[c] = 1'b0;
            endcase
        end
        return r;
    endfunction
    task automatic tick();
        logic [1:0] e_led;
        logic       e_tick;
        e_led  = (rst_n && en) ? model_led(k, mode, duty, phase_inv) : 2'b00;
        e_tick = rst_n && en && (k % 10 == 9);
        @(posedge clk);
        #1;
        k = (rst_n && en) ? k + 1 : 0;
        chk("led_out", {6'd0, led_out}, {6'd0, e_led});
        chk("blink_tick", {7'd0, blink_tick}, {7'd0, e_tick});
    endtask
    initial begin
        int hi;
        // 1: reset held, then always-on
        en = 1'b1; mode = 4'b0101; duty = 8'hFF;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        // 2: complementary blink
        mode = 4'b1010; phase_inv = 2'b10;
        repeat (40) begin
            tick();
            chk("complement", {7'd0, led_out[0] ^ led_out[1]}, 8'd1);
        end
        // 3: duty windows, aligned to a PWM period start
        mode = 4'b0101; phase_inv = 2'b00; duty = 8'h05;
        while (k % 15 != 0) tick();
        hi = 0;
        repeat (15) begin tick(); hi += led_out[0]; end
        chk("duty5_count", 8'(hi), 8'd5);
        duty = 8'h00;
        hi = 0;
        repeat (100) begin tick(); hi += led_out[0] + led_out[1]; end
        chk("duty0_count", 8'(hi), 8'd0);
        // 4: drop en at blink_cnt=6, then re-raise
        mode = 4'b1010; duty = 8'hFF; phase_inv = 2'b01;
        repeat (10) if (k % 10 != 6) tick();
        chk("at_cnt6", 8'(k % 10), 8'd6);
        en = 1'b0;
        repeat (4) tick();
        en = 1'b1;
        repeat (25) tick();
        // 5: async reset mid-cycle while lit
        mode = 4'b0101; duty = 8'hFF;
        repeat (3) tick();
        chk("lit_before_rst", {6'd0, led_out}, 8'h03);
        #3 rst_n = 1'b0;
        #1 chk("async_led", {6'd0, led_out}, 8'h00);
        chk("async_tick", {7'd0, blink_tick}, 8'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (25) tick();
        // 6: breathe ramp over a full triangle and beyond
        mode = 4'b1111; duty = 8'h00;
        repeat (70) tick();
        // randomized mix of modes, duties, phases and occasional enable drops
        repeat (300) begin
            mode      = 4'($urandom);
            duty      = 8'($urandom);
            phase_inv = 2'($urandom);
            en        = $urandom_range(0, 15) != 0;
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
